// File: rtl/sprite_fetch_arbiter_pkg.sv
// Shared types and constants for the two-sprite ROM fetch arbiter.
// The frame bases are word addresses of the 20x20 4bpp frames.
package sprite_fetch_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    A0,
    A1,
    C1
  } state_e;

  localparam int SPR_W        = 20;
  localparam int PIX_PER_WORD = 8;

  localparam logic [9:0] MAN_BASE      = 10'd0;
  localparam logic [9:0] MAN_DEAD_BASE = 10'd50;

  typedef struct packed {
    logic       hit;
    logic [2:0] sel;
    logic [9:0] addr;
  } fetch_t;

endpackage

// File: rtl/sprite_addr_calc.sv
// Sprite box hit test and ROM word address / nibble select.
// Compares in 11 bits so boxes near x=1023 never wrap.
module sprite_addr_calc #(
  parameter int SPR_W        = 20,
  parameter int PIX_PER_WORD = 8
) (
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  input  logic [9:0] spr_x_i,
  input  logic [9:0] spr_y_i,
  input  logic [9:0] base_i,
  output logic       hit_o,
  output logic [9:0] addr_o,
  output logic [2:0] sel_o
);

  localparam int OW = $clog2(SPR_W * SPR_W + 1);

  logic [10:0]   x11;
  logic [10:0]   y11;
  logic [10:0]   sx11;
  logic [10:0]   sy11;
  logic [10:0]   dxo;
  logic [10:0]   dyo;
  logic [10:0]   prod;
  logic [OW-1:0] offset;

  assign x11  = {1'b0, draw_x_i};
  assign y11  = {1'b0, draw_y_i};
  assign sx11 = {1'b0, spr_x_i};
  assign sy11 = {1'b0, spr_y_i};

  assign hit_o = (x11 >= sx11) &&
                 (x11 < sx11 + 11'(SPR_W)) &&
                 (y11 >= sy11) &&
                 (y11 < sy11 + 11'(SPR_W));

  assign dxo    = x11 - sx11;
  assign dyo    = y11 - sy11;
  assign prod   = dyo * 11'(SPR_W);
  assign offset = OW'(dxo + prod);

  assign sel_o  = 3'(offset % OW'(PIX_PER_WORD));
  assign addr_o = base_i + 10'(offset / OW'(PIX_PER_WORD));

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Two-sprite fetch over one shared ROM port: A0 reads sprite 0,
// A1 reads sprite 1, C1 commits both words together.
module sprite_fetch_arbiter
  import sprite_fetch_arbiter_pkg::*;
#(
  parameter int SPR_W        = sprite_fetch_arbiter_pkg::SPR_W,
  parameter int PIX_PER_WORD = sprite_fetch_arbiter_pkg::PIX_PER_WORD
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        pix_en,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  Spr0X,
  input  logic [9:0]  Spr0Y,
  input  logic [9:0]  Spr1X,
  input  logic [9:0]  Spr1Y,
  input  logic [9:0]  spr0_base,
  input  logic [9:0]  spr1_base,
  output logic [9:0]  rom_addr,
  output logic        rom_en,
  input  logic [31:0] rom_data,
  output logic [31:0] word0,
  output logic [31:0] word1,
  output logic [2:0]  sel0,
  output logic [2:0]  sel1,
  output logic        hit0,
  output logic        hit1,
  output logic        out_valid,
  output logic        overrun
);

  logic       c0_hit;
  logic       c1_hit;
  logic [9:0] c0_addr;
  logic [9:0] c1_addr;
  logic [2:0] c0_sel;
  logic [2:0] c1_sel;

  sprite_addr_calc #(
    .SPR_W(SPR_W),
    .PIX_PER_WORD(PIX_PER_WORD)
  ) u_calc0 (
    .draw_x_i(DrawX),
    .draw_y_i(DrawY),
    .spr_x_i (Spr0X),
    .spr_y_i (Spr0Y),
    .base_i  (spr0_base),
    .hit_o   (c0_hit),
    .addr_o  (c0_addr),
    .sel_o   (c0_sel)
  );

  sprite_addr_calc #(
    .SPR_W(SPR_W),
    .PIX_PER_WORD(PIX_PER_WORD)
  ) u_calc1 (
    .draw_x_i(DrawX),
    .draw_y_i(DrawY),
    .spr_x_i (Spr1X),
    .spr_y_i (Spr1Y),
    .base_i  (spr1_base),
    .hit_o   (c1_hit),
    .addr_o  (c1_addr),
    .sel_o   (c1_sel)
  );

  state_e      state_q;
  fetch_t      f0_q;
  fetch_t      f1_q;
  logic [31:0] shadow0_q;
  logic [9:0]  rom_addr_q;
  logic        rom_en_q;
  logic [31:0] word0_q;
  logic [31:0] word1_q;
  logic [2:0]  sel0_q;
  logic [2:0]  sel1_q;
  logic        hit0_q;
  logic        hit1_q;
  logic        out_valid_q;
  logic        overrun_q;

  // Latching the computed hit/addr/sel at accept is equivalent to
  // latching the raw coordinates and keeps the ROM address registered.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      f0_q        <= '0;
      f1_q        <= '0;
      shadow0_q   <= '0;
      rom_addr_q  <= '0;
      rom_en_q    <= 1'b0;
      word0_q     <= '0;
      word1_q     <= '0;
      sel0_q      <= '0;
      sel1_q      <= '0;
      hit0_q      <= 1'b0;
      hit1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        IDLE, C1: begin
          if (state_q == C1) begin
            word0_q     <= f0_q.hit ? shadow0_q : '0;
            word1_q     <= f1_q.hit ? rom_data : '0;
            sel0_q      <= f0_q.hit ? f0_q.sel : '0;
            sel1_q      <= f1_q.hit ? f1_q.sel : '0;
            hit0_q      <= f0_q.hit;
            hit1_q      <= f1_q.hit;
            out_valid_q <= 1'b1;
          end
          if (pix_en) begin
            f0_q     <= '{hit: c0_hit, sel: c0_sel, addr: c0_addr};
            f1_q     <= '{hit: c1_hit, sel: c1_sel, addr: c1_addr};
            rom_en_q <= c0_hit;
            if (c0_hit) rom_addr_q <= c0_addr;
            state_q  <= A0;
          end else begin
            rom_en_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        A0: begin
          if (pix_en) overrun_q <= 1'b1;
          rom_en_q <= f1_q.hit;
          if (f1_q.hit) rom_addr_q <= f1_q.addr;
          state_q  <= A1;
        end
        A1: begin
          if (pix_en) overrun_q <= 1'b1;
          shadow0_q <= f0_q.hit ? rom_data : '0;
          rom_en_q  <= 1'b0;
          state_q   <= C1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rom_en    = rom_en_q;
  assign word0     = word0_q;
  assign word1     = word1_q;
  assign sel0      = sel0_q;
  assign sel1      = sel1_q;
  assign hit0      = hit0_q;
  assign hit1      = hit1_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule
